fir_tap_scheduler: RTL and testbench

- Sequencing controller for the time-multiplexed floating-point FIR tap engine.
- One shared constant-multiple floating-point multiplier, a sample delay-line RAM, a coefficient/multiple ROM and an FP accumulator are reused across all taps of every output sample.
- Per accepted input sample, the block writes the sample into a circular delay line, issues TAPS read/multiply slots, and aligns accumulator control to the multiplier pipeline.
- It then holds the finished result under a valid/ready handshake.

---
 rtl/fir_tap_scheduler_if.sv | 33 +++
 rtl/fir_tap_scheduler.sv | 133 +++++++++++++
 tb/tb_fir_tap_scheduler.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_scheduler_if.sv
// Port bundle between the FIR tap scheduler and its sample source, delay-line RAM,
// coefficient ROM, accumulator and result consumer; master is the scheduler side.
interface fir_tap_scheduler_if #(
    parameter int ADDR_W = 4
) ();
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_sample;
    logic              smp_we;
    logic [ADDR_W-1:0] smp_waddr;
    logic [31:0]       smp_wdata;
    logic [ADDR_W-1:0] smp_raddr;
    logic [ADDR_W-1:0] coef_raddr;
    logic              issue;
    logic              acc_en;
    logic              acc_clr;
    logic              acc_last;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    modport master (
        input  in_valid, in_sample, out_ready,
        output in_ready, smp_we, smp_waddr, smp_wdata, smp_raddr, coef_raddr,
               issue, acc_en, acc_clr, acc_last, out_valid, busy
    );

    modport slave (
        output in_valid, in_sample, out_ready,
        input  in_ready, smp_we, smp_waddr, smp_wdata, smp_raddr, coef_raddr,
               issue, acc_en, acc_clr, acc_last, out_valid, busy
    );
endinterface

// File: rtl/fir_tap_scheduler.sv
// Sequences one shared FP multiplier over TAPS taps per sample; result valid TAPS+PIPE_LAT+2
// cycles after accept. One sample in flight; result held in DONE until out_ready.
module fir_tap_scheduler #(
    parameter int TAPS     = 16,
    parameter int ADDR_W   = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_tap_scheduler_if.master  bus
);
    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] TAPS_A = ADDR_W'(TAPS);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

    logic [2:0]              state_q, state_d;
    logic [ADDR_W-1:0]       wptr_q, wptr_d;
    logic [ADDR_W-1:0]       k_q, k_d;
    logic [31:0]             sample_q, sample_d;
    logic [PIPE_LAT-1:0][2:0] pipe_q, pipe_d;

    logic              issue_now;
    logic              clr_wr;
    logic [2:0]        pipe_out;
    logic [ADDR_W-1:0] rd_addr;

    assign issue_now = (state_q == S_ISSUE);
    assign pipe_out  = pipe_q[PIPE_LAT-1];
    // While reset is held the delay line must not see clear writes.
    assign clr_wr    = (state_q == S_CLEAR) && !rst;

    // Wrap explicitly so a non-power-of-two TAPS stays inside the delay line.
    always_comb begin
        if (wptr_q >= k_q) begin
            rd_addr = wptr_q - k_q;
        end else begin
            rd_addr = wptr_q - k_q + TAPS_A;
        end
    end

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        k_d      = k_q;
        sample_d = sample_q;
        case (state_q)
            S_CLEAR: begin
                if (k_q == K_LAST) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                    wptr_d  = '0;
                end else begin
                    k_d = k_q + ONE_A;
                end
            end
            S_IDLE: begin
                if (bus.in_valid) begin
                    sample_d = bus.in_sample;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_ISSUE;
                k_d     = '0;
            end
            S_ISSUE: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    wptr_d  = (wptr_q == K_LAST) ? '0 : wptr_q + ONE_A;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + ONE_A;
                end
            end
            S_DRAIN: begin
                if (pipe_out[0]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Slot tags ride alongside the RAM read and multiplier registers: {issue, first, last}.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = {issue_now, issue_now && (k_q == '0), issue_now && (k_q == K_LAST)};
        for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_CLEAR;
            wptr_q   <= '0;
            k_q      <= '0;
            sample_q <= '0;
            pipe_q   <= '0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            k_q      <= k_d;
            sample_q <= sample_d;
            pipe_q   <= pipe_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.smp_we     = clr_wr || (state_q == S_WRITE);
    assign bus.smp_waddr  = clr_wr ? k_q : ((state_q == S_WRITE) ? wptr_q : '0);
    assign bus.smp_wdata  = (state_q == S_WRITE) ? sample_q : '0;
    assign bus.smp_raddr  = issue_now ? rd_addr : '0;
    assign bus.coef_raddr = issue_now ? k_q : '0;
    assign bus.issue      = issue_now;
    assign bus.acc_en     = pipe_out[2];
    assign bus.acc_clr    = pipe_out[1];
    assign bus.acc_last   = pipe_out[0];
    assign bus.out_valid  = (state_q == S_DONE);
endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Randomized bench for fir_tap_scheduler: outputs are compared every cycle against an
// offset-from-accept timeline model, on a TAPS=4 instance and a TAPS=5 instance.
module tb_fir_tap_scheduler;
    typedef struct packed {
        logic        in_ready;
        logic        busy;
        logic        smp_we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  raddr;
        logic [3:0]  coef;
        logic        issue;
        logic        acc_en;
        logic        acc_clr;
        logic        acc_last;
        logic        out_valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;
    int   wa = 0;

    always #5 clk = ~clk;

    fir_tap_scheduler_if #(.ADDR_W(4)) a_if ();
    fir_tap_scheduler_if #(.ADDR_W(3)) b_if ();

    fir_tap_scheduler #(.TAPS(4), .ADDR_W(4), .PIPE_LAT(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if)
    );

    fir_tap_scheduler #(.TAPS(5), .ADDR_W(3), .PIPE_LAT(3)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if)
    );

    function automatic exp_t obs_a();
        exp_t o;
        o.in_ready = a_if.in_ready;   o.busy = a_if.busy;
        o.smp_we = a_if.smp_we;       o.waddr = a_if.smp_waddr;
        o.wdata = a_if.smp_wdata;     o.raddr = a_if.smp_raddr;
        o.coef = a_if.coef_raddr;     o.issue = a_if.issue;
        o.acc_en = a_if.acc_en;       o.acc_clr = a_if.acc_clr;
        o.acc_last = a_if.acc_last;   o.out_valid = a_if.out_valid;
        return o;
    endfunction

    function automatic exp_t obs_b();
        exp_t o;
        o.in_ready = b_if.in_ready;         o.busy = b_if.busy;
        o.smp_we = b_if.smp_we;             o.waddr = {1'b0, b_if.smp_waddr};
        o.wdata = b_if.smp_wdata;           o.raddr = {1'b0, b_if.smp_raddr};
        o.coef = {1'b0, b_if.coef_raddr};   o.issue = b_if.issue;
        o.acc_en = b_if.acc_en;             o.acc_clr = b_if.acc_clr;
        o.acc_last = b_if.acc_last;         o.out_valid = b_if.out_valid;
        return o;
    endfunction

    function automatic exp_t exp_idle();
        exp_t e = '0;
        e.in_ready = 1'b1;
        return e;
    endfunction

    function automatic exp_t exp_rst();
        exp_t e = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic exp_t exp_clear(int i);
        exp_t e = '0;
        e.busy   = 1'b1;
        e.smp_we = 1'b1;
        e.waddr  = 4'(i);
        return e;
    endfunction

    // Expected outputs n cycles after the accept cycle of a sample written at slot w.
    function automatic exp_t exp_sample(int n, int w, logic [31:0] s, int t, int p);
        exp_t e = '0;
        e.busy = 1'b1;
        if (n == 1) begin
            e.smp_we = 1'b1;
            e.waddr  = 4'(w);
            e.wdata  = s;
        end
        if (n >= 2 && n <= t + 1) begin
            e.issue = 1'b1;
            e.coef  = 4'(n - 2);
            e.raddr = 4'((w - (n - 2) + t) % t);
        end
        e.acc_en    = (n >= p + 2) && (n <= t + p + 1);
        e.acc_clr   = (n == p + 2);
        e.acc_last  = (n == t + p + 1);
        e.out_valid = (n >= t + p + 2);
        return e;
    endfunction

    task automatic test_reset();
        exp_t got;
        rst_a = 1'b1;
        a_if.in_valid = 1'b0;
        a_if.out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        got = obs_a();
        checks++;
        if (got !== exp_rst()) begin
            errors++;
            $display("FAIL reset_hold got %h exp %h", got, exp_rst());
        end
        @(posedge clk); #1;
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = obs_a();
            checks++;
            if (got !== exp_clear(i)) begin
                errors++;
                $display("FAIL reset_clear i %0d got %h exp %h", i, got, exp_clear(i));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        got = obs_a();
        checks++;
        if (got !== exp_idle()) begin
            errors++;
            $display("FAIL reset_idle got %h exp %h", got, exp_idle());
        end
        @(posedge clk); #1;
        wa = 0;
    endtask

    task automatic test_single();
        exp_t got, exp;
        logic [31:0] s = 32'h3F80_0000;
        a_if.in_valid = 1'b1;
        a_if.in_sample = s;
        a_if.out_ready = 1'b1;
        @(negedge clk);
        got = obs_a();
        checks++;
        if (got !== exp_idle()) begin
            errors++;
            $display("FAIL single_accept got %h exp %h", got, exp_idle());
        end
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            got = obs_a();
            exp = (n <= 8) ? exp_sample(n, wa, s, 4, 2) : exp_idle();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single n %0d got %h exp %h", n, got, exp);
            end
            @(posedge clk); #1;
        end
        wa = (wa + 1) % 4;
    endtask

    task automatic test_back_to_back();
        exp_t got, exp;
        int n = 0;
        int w = 0;
        int acc = 0;
        int w0 = wa;
        int v;
        logic [31:0] s = '0;
        logic [31:0] snext = $urandom;
        int acc_cyc[$];
        int wr_addr[$];
        int rd5[$];
        a_if.out_ready = 1'b1;
        for (int cyc = 0; cyc < 45; cyc++) begin
            a_if.in_valid = 1'b1;
            a_if.in_sample = snext;
            @(negedge clk);
            got = obs_a();
            exp = (n == 0) ? exp_idle() : exp_sample(n, w, s, 4, 2);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b cyc %0d got %h exp %h", cyc, got, exp);
            end
            if (got.in_ready) acc_cyc.push_back(cyc);
            if (got.smp_we) wr_addr.push_back(int'(got.waddr));
            if (acc == 5 && got.issue) rd5.push_back(int'(got.raddr));
            if (n == 0) begin
                s = snext;
                w = wa;
                wa = (wa + 1) % 4;
                acc++;
                n = 1;
                snext = $urandom;
            end else if (n == 8) begin
                n = 0;
            end else begin
                n++;
            end
            @(posedge clk); #1;
        end
        a_if.in_valid = 1'b0;
        checks++;
        if (acc_cyc.size() != 5) begin
            errors++;
            $display("FAIL b2b_accepts got %0d exp 5", acc_cyc.size());
        end
        for (int i = 1; i < 5; i++) begin
            v = (i < acc_cyc.size()) ? acc_cyc[i] - acc_cyc[i-1] : -1;
            checks++;
            if (v != 9) begin
                errors++;
                $display("FAIL b2b_period i %0d got %0d exp 9", i, v);
            end
        end
        for (int i = 0; i < 5; i++) begin
            v = (i < wr_addr.size()) ? wr_addr[i] : -1;
            checks++;
            if (v != (w0 + i) % 4) begin
                errors++;
                $display("FAIL b2b_waddr i %0d got %0d exp %0d", i, v, (w0 + i) % 4);
            end
        end
        for (int k = 0; k < 4; k++) begin
            v = (k < rd5.size()) ? rd5[k] : -1;
            checks++;
            if (v != (w0 - k + 4) % 4) begin
                errors++;
                $display("FAIL b2b_raddr5 k %0d got %0d exp %0d", k, v, (w0 - k + 4) % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t got, exp;
        logic [31:0] s;
        int hold;
        int xfers;
        int ov_cycles;
        for (int r = 0; r < 3; r++) begin
            hold = (r == 0) ? 5 : int'($urandom_range(0, 6));
            xfers = 0;
            ov_cycles = 0;
            s = $urandom;
            a_if.in_valid = 1'b1;
            a_if.in_sample = s;
            a_if.out_ready = 1'b0;
            @(negedge clk);
            got = obs_a();
            checks++;
            if (got !== exp_idle()) begin
                errors++;
                $display("FAIL bp_accept r %0d got %h exp %h", r, got, exp_idle());
            end
            @(posedge clk); #1;
            for (int n = 1; n <= 9 + hold; n++) begin
                a_if.out_ready = (n >= 8 + hold);
                a_if.in_valid = (n < 9 + hold) ? 1'($urandom_range(0, 1)) : 1'b0;
                a_if.in_sample = $urandom;
                @(negedge clk);
                got = obs_a();
                exp = (n <= 8 + hold) ? exp_sample(n, wa, s, 4, 2) : exp_idle();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL bp r %0d n %0d got %h exp %h", r, n, got, exp);
                end
                if (got.out_valid) ov_cycles++;
                if (got.out_valid && a_if.out_ready) xfers++;
                @(posedge clk); #1;
            end
            wa = (wa + 1) % 4;
            checks++;
            if (xfers != 1) begin
                errors++;
                $display("FAIL bp_xfers r %0d got %0d exp 1", r, xfers);
            end
            checks++;
            if (ov_cycles != hold + 1) begin
                errors++;
                $display("FAIL bp_valid_len r %0d got %0d exp %0d", r, ov_cycles, hold + 1);
            end
        end
        a_if.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        exp_t got, exp;
        logic [31:0] s = $urandom;
        a_if.in_valid = 1'b1;
        a_if.in_sample = s;
        a_if.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            if (n == 4) rst_a = 1'b1;
            @(negedge clk);
            got = obs_a();
            exp = exp_sample(n, wa, s, 4, 2);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL midrst_pre n %0d got %h exp %h", n, got, exp);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        got = obs_a();
        checks++;
        if (got !== exp_rst()) begin
            errors++;
            $display("FAIL midrst_hold got %h exp %h", got, exp_rst());
        end
        @(posedge clk); #1;
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = obs_a();
            checks++;
            if (got !== exp_clear(i)) begin
                errors++;
                $display("FAIL midrst_clear i %0d got %h exp %h", i, got, exp_clear(i));
            end
            @(posedge clk); #1;
        end
        wa = 0;
        s = $urandom;
        a_if.in_valid = 1'b1;
        a_if.in_sample = s;
        for (int n = 0; n <= 9; n++) begin
            @(negedge clk);
            got = obs_a();
            exp = (n == 0 || n == 9) ? exp_idle() : exp_sample(n, 0, s, 4, 2);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL midrst_post n %0d got %h exp %h", n, got, exp);
            end
            @(posedge clk); #1;
            a_if.in_valid = 1'b0;
        end
        wa = 1;
    endtask

    task automatic test_npot();
        exp_t got, exp;
        int n = 0;
        int w = 0;
        int acc = 0;
        int v;
        int wb = 0;
        logic [31:0] s = '0;
        logic [31:0] snext = $urandom;
        int exp_rd[5] = '{1, 0, 4, 3, 2};
        int exp_wr[7] = '{0, 1, 2, 3, 4, 0, 1};
        int wr_addr[$];
        int rd2[$];
        b_if.in_valid = 1'b0;
        b_if.out_ready = 1'b1;
        @(negedge clk);
        got = obs_b();
        checks++;
        if (got !== exp_rst()) begin
            errors++;
            $display("FAIL npot_reset got %h exp %h", got, exp_rst());
        end
        @(posedge clk); #1;
        rst_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = obs_b();
            checks++;
            if (got !== exp_clear(i)) begin
                errors++;
                $display("FAIL npot_clear i %0d got %h exp %h", i, got, exp_clear(i));
            end
            @(posedge clk); #1;
        end
        for (int cyc = 0; cyc < 77; cyc++) begin
            b_if.in_valid = 1'b1;
            b_if.in_sample = snext;
            @(negedge clk);
            got = obs_b();
            exp = (n == 0) ? exp_idle() : exp_sample(n, w, s, 5, 3);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL npot cyc %0d got %h exp %h", cyc, got, exp);
            end
            if (got.smp_we) wr_addr.push_back(int'(got.waddr));
            if (acc == 2 && got.issue) rd2.push_back(int'(got.raddr));
            if (n == 0) begin
                s = snext;
                w = wb;
                wb = (wb + 1) % 5;
                acc++;
                n = 1;
                snext = $urandom;
            end else if (n == 10) begin
                n = 0;
            end else begin
                n++;
            end
            @(posedge clk); #1;
        end
        b_if.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            v = (k < rd2.size()) ? rd2[k] : -1;
            checks++;
            if (v != exp_rd[k]) begin
                errors++;
                $display("FAIL npot_raddr k %0d got %0d exp %0d", k, v, exp_rd[k]);
            end
        end
        for (int i = 0; i < 7; i++) begin
            v = (i < wr_addr.size()) ? wr_addr[i] : -1;
            checks++;
            if (v != exp_wr[i]) begin
                errors++;
                $display("FAIL npot_waddr i %0d got %0d exp %0d", i, v, exp_wr[i]);
            end
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.in_valid = 1'b0;
        a_if.in_sample = '0;
        a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0;
        b_if.in_sample = '0;
        b_if.out_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_issue();
        test_npot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
